// File: rtl/bpu_resolve_ctrl.sv
// In-order queue of predicted, unresolved branches between fetch and the gshare predictor.
// Retires the head on EX resolution, drives the predictor update port, and flags mispredicts with a redirect PC.
module bpu_resolve_ctrl #(
  parameter int GSHARE_BITS_NUM      = 5,
  parameter int OPTION_OPERAND_WIDTH = 10,
  parameter int DEPTH                = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            f_valid,
  input  logic                            f_pred,
  input  logic [GSHARE_BITS_NUM-1:0]      f_idx,
  input  logic [OPTION_OPERAND_WIDTH-1:0] f_pc,
  output logic                            f_stall,
  input  logic                            ex_valid,
  input  logic                            ex_taken,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ex_target,
  output logic                            upd_valid,
  output logic                            upd_taken,
  output logic [GSHARE_BITS_NUM-1:0]      upd_idx,
  output logic                            mispredict,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc,
  output logic [$clog2(DEPTH):0]          occupancy,
  output logic                            err_underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]                      state;
  logic                            q_pred [DEPTH];
  logic [GSHARE_BITS_NUM-1:0]      q_idx  [DEPTH];
  logic [OPTION_OPERAND_WIDTH-1:0] q_pc   [DEPTH];
  logic [AW-1:0]                   rd_ptr, wr_ptr;
  logic [AW:0]                     count, count_nx;

  logic full, in_flush, push, pop, mp;
  logic [OPTION_OPERAND_WIDTH-1:0] head_pc_inc;

  // f_stall is a function of registered state only, so fetch sees no combinational path from EX.
  assign full      = (count == (AW+1)'(DEPTH));
  assign in_flush  = (state == FLUSH);
  assign f_stall   = full | in_flush;
  assign push      = f_valid & ~f_stall;
  assign pop       = ex_valid & ~in_flush & (count != '0);
  assign mp        = pop & (q_pred[rd_ptr] ^ ex_taken);
  assign occupancy = count;
  assign head_pc_inc = q_pc[rd_ptr] + OPTION_OPERAND_WIDTH'(1);

  always_comb begin
    count_nx = count;
    if (push && !pop) count_nx = count + (AW+1)'(1);
    else if (pop && !push) count_nx = count - (AW+1)'(1);
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push && !mp) begin
      q_pred[wr_ptr] <= f_pred;
      q_idx[wr_ptr]  <= f_idx;
      q_pc[wr_ptr]   <= f_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      upd_idx       <= '0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      err_underflow <= 1'b0;
    end else begin
      upd_valid  <= pop;
      mispredict <= mp;
      if (pop) begin
        upd_taken   <= ex_taken;
        upd_idx     <= q_idx[rd_ptr];
        redirect_pc <= ex_taken ? ex_target : head_pc_inc;
      end
      if (ex_valid && !in_flush && count == '0) err_underflow <= 1'b1;

      // A mispredict discards everything, including a same-cycle push.
      if (mp) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count_nx;
      end

      case (state)
        IDLE:    if (push) state <= TRACK;
        TRACK: begin
          if (mp) state <= FLUSH;
          else if (pop && !push && count == (AW+1)'(1)) state <= IDLE;
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpu_resolve_ctrl.sv
// Directed plus randomized checks of bpu_resolve_ctrl against a queue-based behavioural model.
module tb_bpu_resolve_ctrl;
  localparam int GB = 5;
  localparam int PW = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_valid, f_pred, ex_valid, ex_taken;
  logic [GB-1:0] f_idx;
  logic [PW-1:0] f_pc, ex_target;
  logic          f_stall, upd_valid, upd_taken, mispredict, err_underflow;
  logic [GB-1:0] upd_idx;
  logic [PW-1:0] redirect_pc;
  logic [$clog2(DEPTH):0] occupancy;

  bpu_resolve_ctrl #(.GSHARE_BITS_NUM(GB), .OPTION_OPERAND_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_pred(f_pred), .f_idx(f_idx), .f_pc(f_pc), .f_stall(f_stall),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_idx(upd_idx),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .occupancy(occupancy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pred;
    bit [GB-1:0] idx;
    bit [PW-1:0] pc;
  } ent_t;

  ent_t        q[$];
  bit          m_flush, m_uf, e_uv, e_ut, e_mp;
  bit [GB-1:0] e_idx;
  bit [PW-1:0] e_rpc;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 0; m_uf = 0; e_uv = 0; e_ut = 0; e_mp = 0; e_idx = '0; e_rpc = '0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":f_stall"}, f_stall, (q.size() == DEPTH) || m_flush);
    chk({ctx, ":upd_valid"}, upd_valid, e_uv);
    chk({ctx, ":upd_taken"}, upd_taken, e_ut);
    chk({ctx, ":upd_idx"}, upd_idx, e_idx);
    chk({ctx, ":mispredict"}, mispredict, e_mp);
    chk({ctx, ":redirect_pc"}, redirect_pc, e_rpc);
    chk({ctx, ":occupancy"}, occupancy, q.size());
    chk({ctx, ":err_underflow"}, err_underflow, m_uf);
  endtask

  // One clock: drive inputs at negedge, advance the model, compare after the edge.
  task automatic step(input string ctx, input bit fv, input bit fp, input bit [GB-1:0] fi,
                      input bit [PW-1:0] fpc, input bit ev, input bit et, input bit [PW-1:0] tg);
    bit   stall, push, pop, mp;
    ent_t h;
    @(negedge clk);
    f_valid = fv; f_pred = fp; f_idx = fi; f_pc = fpc;
    ex_valid = ev; ex_taken = et; ex_target = tg;
    stall = (q.size() == DEPTH) || m_flush;
    push  = fv && !stall;
    pop   = ev && !m_flush && q.size() != 0;
    if (ev && !m_flush && q.size() == 0) m_uf = 1;
    mp = 0;
    e_uv = pop;
    if (pop) begin
      h = q[0];
      mp = (h.pred != et);
      e_ut = et;
      e_idx = h.idx;
      e_rpc = et ? tg : PW'(h.pc + 1);
    end
    e_mp = mp;
    if (mp) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{pred: fp, idx: fi, pc: fpc});
    end
    m_flush = mp;
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic push_b(input string ctx, input bit fp, input bit [GB-1:0] fi, input bit [PW-1:0] fpc);
    step(ctx, 1, fp, fi, fpc, 0, 0, '0);
  endtask

  task automatic resolve(input string ctx, input bit et, input bit [PW-1:0] tg);
    step(ctx, 0, 0, '0, '0, 1, et, tg);
  endtask

  task automatic async_reset(input string ctx);
    @(negedge clk);
    f_valid = 0; ex_valid = 0;
    #2 rst = 1;
    #1 model_reset();
    check_all(ctx);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; f_valid = 0; f_pred = 0; f_idx = '0; f_pc = '0;
    ex_valid = 0; ex_taken = 0; ex_target = '0;
    model_reset();
    #1 check_all("reset");
    repeat (2) @(negedge clk);
    rst = 0;

    // Correctly predicted taken branch retires and the queue returns to empty.
    push_b("t1_push", 1, 5'd5, 10'h010);
    chk("t1_occ_after_push", occupancy, 1);
    resolve("t1_resolve", 1, 10'h050);
    chk("t1_upd_idx", upd_idx, 5);
    chk("t1_occ_after_pop", occupancy, 0);

    // Mispredicted not-taken: fall-through redirect, one-cycle flush window.
    push_b("t2_push", 1, 5'd3, 10'h020);
    resolve("t2_resolve", 0, 10'h100);
    chk("t2_redirect", redirect_pc, 10'h021);
    chk("t2_mispredict", mispredict, 1);
    chk("t2_f_stall_flush", f_stall, 1);
    step("t2_flush_ignores", 1, 1, 5'd9, 10'h099, 1, 0, 10'h0);
    chk("t2_no_underflow_in_flush", err_underflow, 0);
    chk("t2_f_stall_released", f_stall, 0);

    // Fill the queue; push+pop while full refuses the push.
    push_b("t3_p1", 1, 5'd1, 10'h101);
    push_b("t3_p2", 0, 5'd2, 10'h102);
    push_b("t3_p3", 1, 5'd3, 10'h103);
    push_b("t3_p4", 1, 5'd4, 10'h104);
    chk("t3_full_occ", occupancy, 4);
    chk("t3_full_stall", f_stall, 1);
    step("t3_push_pop_full", 1, 1, 5'd7, 10'h107, 1, 1, 10'h200);
    chk("t3_upd_idx", upd_idx, 1);
    chk("t3_occ", occupancy, 3);

    // Head predicted not-taken resolves taken: whole queue and same-cycle push discarded.
    step("t4_mispredict_flush", 1, 1, 5'd8, 10'h108, 1, 1, 10'h3FF);
    chk("t4_redirect", redirect_pc, 10'h3FF);
    chk("t4_occ", occupancy, 0);
    idle("t4_flush_cycle");

    // Resolve with nothing queued: sticky underflow, no update.
    resolve("t5_underflow", 1, 10'h0);
    chk("t5_uf", err_underflow, 1);
    chk("t5_no_update", upd_valid, 0);
    idle("t5_hold1");
    idle("t5_hold2");

    // Randomized traffic, resolutions biased toward the predicted outcome so the queue fills.
    for (int unsigned i = 0; i < 400; i++) begin
      bit fv, fp, ev, et;
      fv = ($urandom_range(0, 9) < 6);
      fp = $urandom_range(0, 1);
      ev = ($urandom_range(0, 9) < 4);
      et = (q.size() != 0 && $urandom_range(0, 9) < 8) ? q[0].pred : 1'($urandom_range(0, 1));
      step("rand", fv, fp, GB'($urandom), PW'($urandom), ev, et, PW'($urandom));
    end

    // Asynchronous reset mid-TRACK, then wrap of the fall-through PC.
    idle("t6_settle");
    idle("t6_settle2");
    async_reset("t6_pre_fill_reset");
    push_b("t6_p1", 1, 5'd10, 10'h111);
    push_b("t6_p2", 0, 5'd11, 10'h112);
    chk("t6_occ2", occupancy, 2);
    async_reset("t6_async_reset");
    chk("t6_uf_cleared", err_underflow, 0);
    push_b("t6_wrap_push", 1, 5'd12, 10'h3FF);
    resolve("t6_wrap_resolve", 0, 10'h123);
    chk("t6_wrap_redirect", redirect_pc, 10'h000);
    idle("t6_tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
